// File: rtl/memory_latch.sv
// memory_latch: MEM stage and MEM/WB pipeline register.
// Rank M holds the instruction from execute and drives the data-memory
// request until dhit; rank W presents registered write-back data/control.
// Optional build macro MEM_FWD_EN adds combinational forwarding outputs
// (fwd_valid, fwd_wsel, fwd_dat) sourced from rank M.
module memory_latch #(
   parameter int ADDR_W    = 32,
   parameter int REG_SEL_W = 5
) (
   input  logic                 CLK,
   input  logic                 nRST,
   input  logic                 mem_en,
   input  logic                 flush,
   input  logic [ADDR_W-1:0]    alu_i,
   input  logic [ADDR_W-1:0]    wdat_i,
   input  logic [ADDR_W-1:0]    pc_i,
   input  logic                 dREN_i,
   input  logic                 dWEN_i,
   input  logic                 reg_wr_i,
   input  logic [REG_SEL_W-1:0] wsel_i,
   input  logic [1:0]           wb_sel_i,
   input  logic                 halt_i,
   input  logic                 dhit,
   input  logic [ADDR_W-1:0]    dmemload,
   output logic                 dmemREN,
   output logic                 dmemWEN,
   output logic [ADDR_W-1:0]    dmemaddr,
   output logic [ADDR_W-1:0]    dmemstore,
   output logic                 mem_stall,
   output logic [ADDR_W-1:0]    wb_dat_o,
   output logic [REG_SEL_W-1:0] wsel_o,
   output logic                 reg_wr_o,
   output logic                 halt_o
`ifdef MEM_FWD_EN
   ,
   output logic                 fwd_valid,
   output logic [REG_SEL_W-1:0] fwd_wsel,
   output logic [ADDR_W-1:0]    fwd_dat
`endif
);

   localparam logic [1:0] WB_MEM  = 2'b01;
   localparam logic [1:0] WB_LINK = 2'b10;

   // rank M
   logic                 m_valid_q,  m_valid_d;
   logic                 m_dren_q,   m_dren_d;
   logic                 m_dwen_q,   m_dwen_d;
   logic                 m_reg_wr_q, m_reg_wr_d;
   logic                 m_halt_q,   m_halt_d;
   logic [REG_SEL_W-1:0] m_wsel_q,   m_wsel_d;
   logic [1:0]           m_wb_sel_q, m_wb_sel_d;
   logic [ADDR_W-1:0]    m_alu_q,    m_alu_d;
   logic [ADDR_W-1:0]    m_wdat_q,   m_wdat_d;
   logic [ADDR_W-1:0]    m_pc_q,     m_pc_d;

   // rank W
   logic                 w_reg_wr_q, w_reg_wr_d;
   logic [REG_SEL_W-1:0] w_wsel_q,   w_wsel_d;
   logic [ADDR_W-1:0]    w_dat_q,    w_dat_d;
   logic                 halt_q,     halt_d;

   logic                 m_busy;
   logic                 m_retire;
   logic [ADDR_W-1:0]    m_link;

   // M holds a memory access; it stalls until the dhit cycle
   assign m_busy    = m_valid_q & (m_dren_q | m_dwen_q);
   assign mem_stall = m_busy & ~dhit;
   assign m_retire  = m_valid_q & ~mem_stall;
   assign m_link    = m_pc_q + ADDR_W'(4);

   assign dmemREN   = m_valid_q & m_dren_q;
   assign dmemWEN   = m_valid_q & m_dwen_q;
   assign dmemaddr  = m_alu_q;
   assign dmemstore = m_wdat_q;

   assign wb_dat_o  = w_dat_q;
   assign wsel_o    = w_wsel_q;
   assign reg_wr_o  = w_reg_wr_q;
   assign halt_o    = halt_q;

`ifdef MEM_FWD_EN
   // loads are excluded: their data is not known until W
   assign fwd_valid = m_valid_q & m_reg_wr_q & ~m_dren_q;
   assign fwd_wsel  = m_wsel_q;
   assign fwd_dat   = (m_wb_sel_q == WB_LINK) ? m_link : m_alu_q;
`endif

   // rank M next state: stall > halted > flush > capture > bubble
   always_comb begin
      m_valid_d  = m_valid_q;
      m_dren_d   = m_dren_q;
      m_dwen_d   = m_dwen_q;
      m_reg_wr_d = m_reg_wr_q;
      m_halt_d   = m_halt_q;
      m_wsel_d   = m_wsel_q;
      m_wb_sel_d = m_wb_sel_q;
      m_alu_d    = m_alu_q;
      m_wdat_d   = m_wdat_q;
      m_pc_d     = m_pc_q;
      if (mem_stall) begin
         // request must stay stable until dhit
      end else if (halt_q || flush) begin
         m_valid_d  = 1'b0;
         m_dren_d   = 1'b0;
         m_dwen_d   = 1'b0;
         m_reg_wr_d = 1'b0;
         m_halt_d   = 1'b0;
      end else if (mem_en) begin
         m_valid_d  = 1'b1;
         // simultaneous read+write is treated as a store only
         m_dren_d   = dREN_i & ~dWEN_i;
         m_dwen_d   = dWEN_i;
         m_reg_wr_d = reg_wr_i;
         m_halt_d   = halt_i;
         m_wsel_d   = wsel_i;
         m_wb_sel_d = wb_sel_i;
         m_alu_d    = alu_i;
         m_wdat_d   = wdat_i;
         m_pc_d     = pc_i;
      end else begin
         m_valid_d  = 1'b0;
      end
   end

   // rank M registers
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         m_valid_q  <= 1'b0;
         m_dren_q   <= 1'b0;
         m_dwen_q   <= 1'b0;
         m_reg_wr_q <= 1'b0;
         m_halt_q   <= 1'b0;
         m_wsel_q   <= '0;
         m_wb_sel_q <= '0;
         m_alu_q    <= '0;
         m_wdat_q   <= '0;
         m_pc_q     <= '0;
      end else begin
         m_valid_q  <= m_valid_d;
         m_dren_q   <= m_dren_d;
         m_dwen_q   <= m_dwen_d;
         m_reg_wr_q <= m_reg_wr_d;
         m_halt_q   <= m_halt_d;
         m_wsel_q   <= m_wsel_d;
         m_wb_sel_q <= m_wb_sel_d;
         m_alu_q    <= m_alu_d;
         m_wdat_q   <= m_wdat_d;
         m_pc_q     <= m_pc_d;
      end
   end

   // rank W next state: load on retire, otherwise drop the write enable
   always_comb begin
      w_reg_wr_d = 1'b0;
      w_wsel_d   = w_wsel_q;
      w_dat_d    = w_dat_q;
      halt_d     = halt_q;
      if (m_retire) begin
         w_reg_wr_d = m_reg_wr_q;
         w_wsel_d   = m_wsel_q;
         halt_d     = halt_q | m_halt_q;
         case (m_wb_sel_q)
            WB_MEM:  w_dat_d = dmemload;
            WB_LINK: w_dat_d = m_link;
            default: w_dat_d = m_alu_q;
         endcase
      end
   end

   // rank W registers; halt is sticky until reset
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         w_reg_wr_q <= 1'b0;
         w_wsel_q   <= '0;
         w_dat_q    <= '0;
         halt_q     <= 1'b0;
      end else begin
         w_reg_wr_q <= w_reg_wr_d;
         w_wsel_q   <= w_wsel_d;
         w_dat_q    <= w_dat_d;
         halt_q     <= halt_d;
      end
   end

endmodule

// File: tb/tb_memory_latch.sv
// Testbench for memory_latch: write-back expectations are queued when an
// instruction is driven and popped when reg_wr_o is observed.
module tb_memory_latch;

   logic        CLK = 1'b0;
   logic        nRST;
   logic        mem_en, flush;
   logic [31:0] alu_i, wdat_i, pc_i;
   logic        dREN_i, dWEN_i, reg_wr_i;
   logic [4:0]  wsel_i;
   logic [1:0]  wb_sel_i;
   logic        halt_i, dhit;
   logic [31:0] dmemload;
   logic        dmemREN, dmemWEN;
   logic [31:0] dmemaddr, dmemstore;
   logic        mem_stall;
   logic [31:0] wb_dat_o;
   logic [4:0]  wsel_o;
   logic        reg_wr_o, halt_o;
`ifdef MEM_FWD_EN
   logic        fwd_valid;
   logic [4:0]  fwd_wsel;
   logic [31:0] fwd_dat;
`endif

   typedef struct {
      logic [4:0]  wsel;
      logic [31:0] dat;
   } wb_t;

   wb_t sb[$];
   wb_t exp;
   int  checks   = 0;
   int  failures = 0;

   memory_latch dut (
      .CLK(CLK), .nRST(nRST), .mem_en(mem_en), .flush(flush),
      .alu_i(alu_i), .wdat_i(wdat_i), .pc_i(pc_i),
      .dREN_i(dREN_i), .dWEN_i(dWEN_i), .reg_wr_i(reg_wr_i),
      .wsel_i(wsel_i), .wb_sel_i(wb_sel_i), .halt_i(halt_i),
      .dhit(dhit), .dmemload(dmemload),
      .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
      .dmemstore(dmemstore), .mem_stall(mem_stall),
      .wb_dat_o(wb_dat_o), .wsel_o(wsel_o), .reg_wr_o(reg_wr_o),
      .halt_o(halt_o)
`ifdef MEM_FWD_EN
      , .fwd_valid(fwd_valid), .fwd_wsel(fwd_wsel), .fwd_dat(fwd_dat)
`endif
   );

   always #5 CLK = ~CLK;

   task automatic clr_in();
      mem_en = 0; flush = 0; alu_i = 0; wdat_i = 0; pc_i = 0;
      dREN_i = 0; dWEN_i = 0; reg_wr_i = 0; wsel_i = 0; wb_sel_i = 0;
      halt_i = 0; dhit = 0; dmemload = 0;
   endtask

   // advance to just after the next rising edge (input drive point)
   task automatic step();
      @(posedge CLK); #1;
   endtask

   task automatic test_reset();
      nRST = 1'b1; clr_in();
      #2 nRST = 1'b0;
      #1;
      checks++;
      if ({dmemREN, dmemWEN, mem_stall, reg_wr_o, halt_o} !== 5'b0) begin
         failures++;
         $display("FAIL reset_ctrl got=%b exp=00000", {dmemREN, dmemWEN, mem_stall, reg_wr_o, halt_o});
      end
      checks++;
      if (wb_dat_o !== 32'h0) begin failures++; $display("FAIL reset_wb_dat got=%h exp=0", wb_dat_o); end
      checks++;
      if (wsel_o !== 5'd0) begin failures++; $display("FAIL reset_wsel got=%0d exp=0", wsel_o); end
      @(negedge CLK); @(negedge CLK);
      nRST = 1'b1;
      step();
   endtask

   task automatic test_alu();
      alu_i = 32'h0000_1234; wsel_i = 5'd3; reg_wr_i = 1; wb_sel_i = 2'b00; mem_en = 1;
      sb.push_back('{5'd3, 32'h0000_1234});
      @(negedge CLK);
      checks++;
      if (mem_stall !== 1'b0) begin failures++; $display("FAIL alu_stall0 got=%b exp=0", mem_stall); end
      step(); clr_in();
      @(negedge CLK);
      checks++;
      if ({mem_stall, reg_wr_o} !== 2'b00) begin failures++; $display("FAIL alu_early got=%b exp=00", {mem_stall, reg_wr_o}); end
      step();
      @(negedge CLK);
      checks++;
      if (reg_wr_o !== 1'b1 || sb.size() == 0) begin
         failures++; $display("FAIL alu_wb_en got=%b queued=%0d", reg_wr_o, sb.size());
      end else begin
         exp = sb.pop_front();
         checks++;
         if (wsel_o !== exp.wsel || wb_dat_o !== exp.dat) begin
            failures++; $display("FAIL alu_wb got=%0d/%h exp=%0d/%h", wsel_o, wb_dat_o, exp.wsel, exp.dat);
         end
      end
      step();
      @(negedge CLK);
      checks++;
      if (reg_wr_o !== 1'b0) begin failures++; $display("FAIL alu_bubble got=%b exp=0", reg_wr_o); end
      step();
   endtask

   task automatic test_load();
      alu_i = 32'h100; dREN_i = 1; wb_sel_i = 2'b01; wsel_i = 5'd5; reg_wr_i = 1; mem_en = 1;
      sb.push_back('{5'd5, 32'hDEAD_BEEF});
      step(); clr_in();
      for (int c = 0; c < 3; c++) begin
         if (c == 2) begin dhit = 1; dmemload = 32'hDEAD_BEEF; end
         @(negedge CLK);
         checks++;
         if ({dmemREN, dmemWEN} !== 2'b10 || dmemaddr !== 32'h100 || mem_stall !== (c < 2)) begin
            failures++;
            $display("FAIL load_req_c%0d got=ren%b wen%b addr=%h stall=%b exp=ren1 wen0 addr=100 stall=%b",
                     c, dmemREN, dmemWEN, dmemaddr, mem_stall, c < 2);
         end
         step();
      end
      dhit = 0; dmemload = 32'h0;
      @(negedge CLK);
      checks++;
      if (reg_wr_o !== 1'b1 || sb.size() == 0) begin
         failures++; $display("FAIL load_wb_en got=%b queued=%0d", reg_wr_o, sb.size());
      end else begin
         exp = sb.pop_front();
         checks++;
         if (wsel_o !== exp.wsel || wb_dat_o !== exp.dat) begin
            failures++; $display("FAIL load_wb got=%0d/%h exp=%0d/%h", wsel_o, wb_dat_o, exp.wsel, exp.dat);
         end
      end
      checks++;
      if (dmemREN !== 1'b0) begin failures++; $display("FAIL load_release got=%b exp=0", dmemREN); end
      step();
   endtask

   task automatic test_store_stall();
      alu_i = 32'h200; wdat_i = 32'hCAFE; dWEN_i = 1; mem_en = 1;
      step();
      // competing instruction plus flush while the store is stalled
      alu_i = 32'h300; wdat_i = 32'h1111; dWEN_i = 0; dREN_i = 1; reg_wr_i = 1; flush = 1; mem_en = 1;
      for (int c = 0; c < 3; c++) begin
         if (c == 1) flush = 0;
         if (c == 2) begin clr_in(); dhit = 1; end
         @(negedge CLK);
         checks++;
         if ({dmemREN, dmemWEN} !== 2'b01 || dmemaddr !== 32'h200 || dmemstore !== 32'hCAFE
             || mem_stall !== (c < 2)) begin
            failures++;
            $display("FAIL store_hold_c%0d got=ren%b wen%b addr=%h dat=%h stall=%b exp=ren0 wen1 addr=200 dat=cafe stall=%b",
                     c, dmemREN, dmemWEN, dmemaddr, dmemstore, mem_stall, c < 2);
         end
         step();
      end
      dhit = 0;
      @(negedge CLK);
      checks++;
      if ({reg_wr_o, dmemREN, dmemWEN} !== 3'b000) begin
         failures++; $display("FAIL store_after got=%b exp=000", {reg_wr_o, dmemREN, dmemWEN});
      end
      step();
   endtask

   task automatic test_load_store_both();
      alu_i = 32'h400; wdat_i = 32'h77; dREN_i = 1; dWEN_i = 1; reg_wr_i = 1; wsel_i = 5'd7; mem_en = 1;
      sb.push_back('{5'd7, 32'h400});
      step(); clr_in(); dhit = 1;
      @(negedge CLK);
      checks++;
      if ({dmemREN, dmemWEN, mem_stall} !== 3'b010) begin
         failures++; $display("FAIL both_req got=%b exp=010", {dmemREN, dmemWEN, mem_stall});
      end
      step(); dhit = 0;
      @(negedge CLK);
      checks++;
      if (reg_wr_o !== 1'b1 || sb.size() == 0) begin
         failures++; $display("FAIL both_wb_en got=%b queued=%0d", reg_wr_o, sb.size());
      end else begin
         exp = sb.pop_front();
         checks++;
         if (wsel_o !== exp.wsel || wb_dat_o !== exp.dat) begin
            failures++; $display("FAIL both_wb got=%0d/%h exp=%0d/%h", wsel_o, wb_dat_o, exp.wsel, exp.dat);
         end
      end
      step();
   endtask

   task automatic test_flush();
      alu_i = 32'h500; dREN_i = 1; reg_wr_i = 1; wsel_i = 5'd9; flush = 1; mem_en = 1;
      step(); clr_in();
      @(negedge CLK);
      checks++;
      if ({dmemREN, dmemWEN, mem_stall, reg_wr_o} !== 4'b0000) begin
         failures++; $display("FAIL flush_m got=%b exp=0000", {dmemREN, dmemWEN, mem_stall, reg_wr_o});
      end
      step();
      @(negedge CLK);
      checks++;
      if (reg_wr_o !== 1'b0) begin failures++; $display("FAIL flush_w got=%b exp=0", reg_wr_o); end
      step();
   endtask

   task automatic test_jal_wrap();
      pc_i = 32'hFFFF_FFFC; alu_i = 32'h1234_5678; wb_sel_i = 2'b10; wsel_i = 5'd31; reg_wr_i = 1; mem_en = 1;
      sb.push_back('{5'd31, 32'h0000_0000});
      step(); clr_in();
      step();
      @(negedge CLK);
      checks++;
      if (reg_wr_o !== 1'b1 || sb.size() == 0) begin
         failures++; $display("FAIL jal_wb_en got=%b queued=%0d", reg_wr_o, sb.size());
      end else begin
         exp = sb.pop_front();
         checks++;
         if (wsel_o !== exp.wsel || wb_dat_o !== exp.dat) begin
            failures++; $display("FAIL jal_wb got=%0d/%h exp=%0d/%h", wsel_o, wb_dat_o, exp.wsel, exp.dat);
         end
      end
      step();
   endtask

   task automatic test_back_to_back();
      logic [31:0] a, p;
      logic [1:0]  s;
      logic [4:0]  w;
      for (int i = 0; i < 4; i++) begin
         a = $urandom; p = $urandom; w = 5'($urandom_range(1, 31));
         s = (i == 1) ? 2'b10 : ((i == 2) ? 2'b11 : 2'b00);
         alu_i = a; pc_i = p; wb_sel_i = s; wsel_i = w; reg_wr_i = 1; mem_en = 1;
         sb.push_back('{w, (s == 2'b10) ? p + 32'd4 : a});
         step();
         if (i > 0) begin
            @(negedge CLK);
            checks++;
            if (reg_wr_o !== 1'b1 || sb.size() == 0) begin
               failures++; $display("FAIL b2b_wb_en%0d got=%b queued=%0d", i - 1, reg_wr_o, sb.size());
            end else begin
               exp = sb.pop_front();
               checks++;
               if (wsel_o !== exp.wsel || wb_dat_o !== exp.dat) begin
                  failures++; $display("FAIL b2b_wb%0d got=%0d/%h exp=%0d/%h", i - 1, wsel_o, wb_dat_o, exp.wsel, exp.dat);
               end
            end
         end
      end
      clr_in();
      step();
      @(negedge CLK);
      checks++;
      if (reg_wr_o !== 1'b1 || sb.size() == 0) begin
         failures++; $display("FAIL b2b_wb_en3 got=%b queued=%0d", reg_wr_o, sb.size());
      end else begin
         exp = sb.pop_front();
         checks++;
         if (wsel_o !== exp.wsel || wb_dat_o !== exp.dat) begin
            failures++; $display("FAIL b2b_wb3 got=%0d/%h exp=%0d/%h", wsel_o, wb_dat_o, exp.wsel, exp.dat);
         end
      end
      step();
   endtask

   task automatic test_halt();
      alu_i = 32'h600; dREN_i = 1; wb_sel_i = 2'b01; wsel_i = 5'd9; reg_wr_i = 1; mem_en = 1;
      sb.push_back('{5'd9, 32'h5A5A_5A5A});
      step();
      clr_in(); halt_i = 1; mem_en = 1;          // halt waits behind the load
      step();
      dhit = 1; dmemload = 32'h5A5A_5A5A;
      step();
      clr_in();
      @(negedge CLK);
      checks++;
      if (reg_wr_o !== 1'b1 || halt_o !== 1'b0 || sb.size() == 0) begin
         failures++; $display("FAIL halt_load_first got=wr%b halt%b queued=%0d exp=wr1 halt0", reg_wr_o, halt_o, sb.size());
      end else begin
         exp = sb.pop_front();
         checks++;
         if (wsel_o !== exp.wsel || wb_dat_o !== exp.dat) begin
            failures++; $display("FAIL halt_load_wb got=%0d/%h exp=%0d/%h", wsel_o, wb_dat_o, exp.wsel, exp.dat);
         end
      end
      step();
      @(negedge CLK);
      checks++;
      if (halt_o !== 1'b1 || reg_wr_o !== 1'b0) begin
         failures++; $display("FAIL halt_set got=halt%b wr%b exp=halt1 wr0", halt_o, reg_wr_o);
      end
      for (int i = 0; i < 3; i++) begin
         alu_i = 32'h700 + 32'(i); dREN_i = 1; reg_wr_i = 1; wsel_i = 5'd4; mem_en = 1;
         step();
         @(negedge CLK);
         checks++;
         if ({halt_o, reg_wr_o, dmemREN, mem_stall} !== 4'b1000) begin
            failures++; $display("FAIL halt_ignore%0d got=%b exp=1000", i, {halt_o, reg_wr_o, dmemREN, mem_stall});
         end
      end
      clr_in();
      #2 nRST = 1'b0;
      #1;
      checks++;
      if (halt_o !== 1'b0) begin failures++; $display("FAIL halt_async_clr got=%b exp=0", halt_o); end
      @(negedge CLK);
      nRST = 1'b1;
      step();
   endtask

   task automatic test_reset_mid_access();
      alu_i = 32'h800; dREN_i = 1; reg_wr_i = 1; wsel_i = 5'd2; wb_sel_i = 2'b01; mem_en = 1;
      step(); clr_in();
      @(negedge CLK);
      checks++;
      if ({dmemREN, mem_stall} !== 2'b11) begin failures++; $display("FAIL rst_mid_pre got=%b exp=11", {dmemREN, mem_stall}); end
      #1 nRST = 1'b0;
      #1;
      checks++;
      if ({dmemREN, mem_stall} !== 2'b00) begin failures++; $display("FAIL rst_mid_drop got=%b exp=00", {dmemREN, mem_stall}); end
      @(negedge CLK);
      nRST = 1'b1;
      step();
      @(negedge CLK);
      checks++;
      if ({dmemREN, reg_wr_o} !== 2'b00) begin failures++; $display("FAIL rst_mid_noretry got=%b exp=00", {dmemREN, reg_wr_o}); end
      step();
   endtask

   initial begin
      test_reset();
      test_alu();
      test_load();
      test_store_stall();
      test_load_store_both();
      test_flush();
      test_jal_wrap();
      test_back_to_back();
      test_halt();
      test_reset_mid_access();
      checks++;
      if (sb.size() != 0) begin failures++; $display("FAIL sb_leftover got=%0d exp=0", sb.size()); end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
